// File: rtl/axi_lite_pkg.sv
// Shared constants and state types for the AXI4-Lite register responder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package axi_lite_pkg;

    // Response code: every access completes OKAY
    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Byte offsets of the four registers
    localparam logic [3:0] REG0_OFFSET = 4'h0;
    localparam logic [3:0] REG1_OFFSET = 4'h4;
    localparam logic [3:0] REG2_OFFSET = 4'h8;
    localparam logic [3:0] REG3_OFFSET = 4'hC;

    // Write side: collecting AW/W, then presenting the B response
    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_t;

    // Read side: accepting AR, then presenting R data
    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    // Merge new write data into an old register value, one byte lane per strobe bit
    function automatic logic [31:0] apply_strb(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = new_val[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_lite_reg_responder.sv
// AXI4-Lite slave with four 32-bit R/W registers exported as live outputs.
// Latency: write commits on the later AW/W handshake edge, BVALID next cycle; RVALID one cycle after AR handshake.
// Backpressure: BVALID/RVALID hold until BREADY/RREADY; AW/W/AR READY stay low until the pending response drains.
module axi_lite_reg_responder
    import axi_lite_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    // write address channel
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    // write data channel
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [3:0]                      S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    // write response channel
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    // read address channel
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    // read data channel
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    // live register contents
    output logic [C_S_AXI_DATA_WIDTH-1:0]   REG0_OUT,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   REG1_OUT,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   REG2_OUT,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   REG3_OUT
);

    // Register file
    logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];

    // Write-side state and holding latches for an early AW or W beat
    w_state_t                      w_state;
    logic                          aw_cap_q;
    logic                          w_cap_q;
    logic [1:0]                    aw_idx_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q;
    logic [3:0]                    wstrb_q;
    logic                          awready_q;
    logic                          wready_q;
    logic                          bvalid_q;

    // Read-side state
    r_state_t                      r_state;
    logic                          arready_q;
    logic                          rvalid_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;

    // Handshake strobes and the effective write beat for this cycle
    logic                          aw_hs;
    logic                          w_hs;
    logic                          ar_hs;
    logic                          aw_have;
    logic                          w_have;
    logic [1:0]                    wr_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0] wr_data;
    logic [3:0]                    wr_strb;
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_mux;

    // PROT and the unused address bits carry no meaning for this block
    logic unused_ok;
    assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

    assign aw_hs = S_AXI_AWVALID & awready_q;
    assign w_hs  = S_AXI_WVALID  & wready_q;
    assign ar_hs = S_AXI_ARVALID & arready_q;

    // Select between a beat arriving this cycle and one already latched
    always_comb begin
        aw_have = aw_cap_q | aw_hs;
        w_have  = w_cap_q  | w_hs;
        wr_idx  = aw_hs ? S_AXI_AWADDR[3:2] : aw_idx_q;
        wr_data = w_hs  ? S_AXI_WDATA       : wdata_q;
        wr_strb = w_hs  ? S_AXI_WSTRB       : wstrb_q;
    end

    // Read mux on the address currently offered; sampled only on an AR handshake
    always_comb begin
        rd_mux = regs[S_AXI_ARADDR[3:2]];
    end

    // Write FSM: gather AW and W in any order, commit, then hold B until accepted
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            w_state   <= W_IDLE;
            aw_cap_q  <= 1'b0;
            w_cap_q   <= 1'b0;
            aw_idx_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_cap_q <= 1'b1;
                        aw_idx_q <= S_AXI_AWADDR[3:2];
                    end
                    if (w_hs) begin
                        w_cap_q <= 1'b1;
                        wdata_q <= S_AXI_WDATA;
                        wstrb_q <= S_AXI_WSTRB;
                    end
                    // Each READY drops once its own beat is held
                    awready_q <= ~aw_have;
                    wready_q  <= ~w_have;
                    if (aw_have && w_have) begin
                        regs[wr_idx] <= apply_strb(regs[wr_idx], wr_data, wr_strb);
                        bvalid_q     <= 1'b1;
                        w_state      <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid_q  <= 1'b0;
                        aw_cap_q  <= 1'b0;
                        w_cap_q   <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        w_state   <= W_IDLE;
                    end
                end
                default: begin
                    w_state <= W_IDLE;
                end
            endcase
        end
    end

    // Read FSM: capture the selected register on AR, hold R until accepted
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (ar_hs) begin
                        // Non-blocking read of regs yields the pre-commit value on a same-edge write
                        rdata_q   <= rd_mux;
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        r_state   <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        r_state   <= R_IDLE;
                    end
                end
                default: begin
                    r_state <= R_IDLE;
                end
            endcase
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = RESP_OKAY;

    assign REG0_OUT = regs[0];
    assign REG1_OUT = regs[1];
    assign REG2_OUT = regs[2];
    assign REG3_OUT = regs[3];

endmodule

// File: tb/tb_axi_lite_reg_responder.sv
// Directed bench for axi_lite_reg_responder with a read/write response scoreboard.
// Latency: n/a (testbench).
// Backpressure: exercises held BREADY/RREADY and skewed AW/W arrival.
module tb_axi_lite_reg_responder;

    logic        tb_ACLK;
    logic        ARESETN;
    logic [3:0]  S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [3:0]  S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic [31:0] REG0_OUT;
    logic [31:0] REG1_OUT;
    logic [31:0] REG2_OUT;
    logic [31:0] REG3_OUT;

    axi_lite_reg_responder #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4)
    ) dut (
        .ACLK          (tb_ACLK),
        .ARESETN       (ARESETN),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .REG0_OUT      (REG0_OUT),
        .REG1_OUT      (REG1_OUT),
        .REG2_OUT      (REG2_OUT),
        .REG3_OUT      (REG3_OUT)
    );

    initial tb_ACLK = 1'b0;
    always #5 tb_ACLK = ~tb_ACLK;

    int unsigned passed = 0;
    int unsigned total  = 0;

    // Reference register contents and pending-response scoreboards
    logic [31:0] model [4];
    logic [31:0] rd_q [$];
    logic [1:0]  b_q  [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
        return r;
    endfunction

    // Drive AW+W together; when hold is set, leave BREADY low and return with BVALID pending
    task automatic do_write(input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input bit hold);
        bit aw_done = 0;
        bit w_done  = 0;
        int cyc     = 0;
        logic [1:0] exp_b;
        @(negedge tb_ACLK);
        S_AXI_AWADDR  = addr;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA   = data;
        S_AXI_WSTRB   = strb;
        S_AXI_WVALID  = 1'b1;
        S_AXI_BREADY  = ~hold;
        model[addr[3:2]] = merge(model[addr[3:2]], data, strb);
        b_q.push_back(2'b00);
        while (!(aw_done && w_done) && cyc < 20) begin
            if (S_AXI_AWVALID && S_AXI_AWREADY) aw_done = 1;
            if (S_AXI_WVALID && S_AXI_WREADY) w_done = 1;
            @(negedge tb_ACLK);
            cyc++;
            if (aw_done) S_AXI_AWVALID = 1'b0;
            if (w_done)  S_AXI_WVALID  = 1'b0;
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        cyc = 0;
        while (!S_AXI_BVALID && cyc < 20) begin
            @(negedge tb_ACLK);
            cyc++;
        end
        check("write_bvalid_seen", {31'b0, S_AXI_BVALID}, 32'd1);
        exp_b = b_q.pop_front();
        check("write_bresp", {30'b0, S_AXI_BRESP}, {30'b0, exp_b});
        if (!hold) @(negedge tb_ACLK);
    endtask

    task automatic do_read(input logic [3:0] addr, input string tag);
        int cyc = 0;
        logic [31:0] exp_d;
        @(negedge tb_ACLK);
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        S_AXI_RREADY  = 1'b1;
        rd_q.push_back(model[addr[3:2]]);
        while (!S_AXI_ARREADY && cyc < 20) begin
            @(negedge tb_ACLK);
            cyc++;
        end
        @(negedge tb_ACLK);
        S_AXI_ARVALID = 1'b0;
        cyc = 0;
        while (!S_AXI_RVALID && cyc < 20) begin
            @(negedge tb_ACLK);
            cyc++;
        end
        check({tag, "_rvalid_seen"}, {31'b0, S_AXI_RVALID}, 32'd1);
        exp_d = rd_q.pop_front();
        check({tag, "_rdata"}, S_AXI_RDATA, exp_d);
        check({tag, "_rresp"}, {30'b0, S_AXI_RRESP}, 32'd0);
        @(negedge tb_ACLK);
    endtask

    logic [31:0] exp_tmp;

    initial begin
        ARESETN       = 1'b0;
        S_AXI_AWADDR  = '0;
        S_AXI_AWPROT  = '0;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA   = '0;
        S_AXI_WSTRB   = '0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b1;
        S_AXI_ARADDR  = '0;
        S_AXI_ARPROT  = '0;
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b1;
        for (int i = 0; i < 4; i++) model[i] = '0;

        // Reset state
        repeat (3) @(negedge tb_ACLK);
        check("rst_awready", {31'b0, S_AXI_AWREADY}, 32'd0);
        check("rst_wready",  {31'b0, S_AXI_WREADY},  32'd0);
        check("rst_arready", {31'b0, S_AXI_ARREADY}, 32'd0);
        check("rst_bvalid",  {31'b0, S_AXI_BVALID},  32'd0);
        check("rst_rvalid",  {31'b0, S_AXI_RVALID},  32'd0);
        check("rst_reg0",    REG0_OUT, 32'h0);
        check("rst_rdata",   S_AXI_RDATA, 32'h0);
        ARESETN = 1'b1;
        @(negedge tb_ACLK);
        check("post_rst_awready", {31'b0, S_AXI_AWREADY}, 32'd1);
        check("post_rst_wready",  {31'b0, S_AXI_WREADY},  32'd1);
        check("post_rst_arready", {31'b0, S_AXI_ARREADY}, 32'd1);

        // Basic write/read
        do_write(4'h0, 32'h0101FFFF, 4'hF, 1'b0);
        do_read(4'h0, "basic_r0");

        // Sequential registers
        do_write(4'h4, 32'habcd0001, 4'hF, 1'b0);
        do_read(4'h4, "seq_r1");
        do_write(4'h8, 32'hdead0011, 4'hF, 1'b0);
        do_read(4'h8, "seq_r2");
        do_write(4'hC, 32'hbeef0011, 4'hF, 1'b0);
        do_read(4'hC, "seq_r3");
        check("reg1_out", REG1_OUT, 32'habcd0001);
        check("reg2_out", REG2_OUT, 32'hdead0011);
        check("reg3_out", REG3_OUT, 32'hbeef0011);

        // Ignored low address bits alias onto the register
        do_read(4'h7, "alias_r1");

        // W arrives well ahead of AW
        @(negedge tb_ACLK);
        S_AXI_WDATA  = 32'h12345678;
        S_AXI_WSTRB  = 4'hF;
        S_AXI_WVALID = 1'b1;
        S_AXI_AWADDR = 4'h4;
        S_AXI_BREADY = 1'b1;
        check("skew_wready_before", {31'b0, S_AXI_WREADY}, 32'd1);
        @(negedge tb_ACLK);
        S_AXI_WVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("skew_wready_low", {31'b0, S_AXI_WREADY}, 32'd0);
            check("skew_awready_hi", {31'b0, S_AXI_AWREADY}, 32'd1);
            check("skew_bvalid_low", {31'b0, S_AXI_BVALID}, 32'd0);
            if (i < 2) @(negedge tb_ACLK);
        end
        S_AXI_AWVALID = 1'b1;
        model[1] = 32'h12345678;
        @(negedge tb_ACLK);
        S_AXI_AWVALID = 1'b0;
        check("skew_bvalid_next", {31'b0, S_AXI_BVALID}, 32'd1);
        check("skew_awready_low", {31'b0, S_AXI_AWREADY}, 32'd0);
        check("skew_reg1_out", REG1_OUT, 32'h12345678);
        @(negedge tb_ACLK);
        check("skew_bvalid_done", {31'b0, S_AXI_BVALID}, 32'd0);
        check("skew_ready_back",  {30'b0, S_AXI_AWREADY, S_AXI_WREADY}, 32'd3);
        do_read(4'h4, "skew_r1");

        // Byte strobes
        do_write(4'h0, 32'hFFFFFFFF, 4'hF, 1'b0);
        do_write(4'h0, 32'h00000000, 4'b0011, 1'b0);
        do_read(4'h0, "strb_r0");
        check("strb_model", model[0], 32'hFFFF0000);
        do_write(4'h8, 32'h12345678, 4'b0000, 1'b0);
        do_read(4'h8, "strb0_r2");

        // Held B response while reads proceed
        do_write(4'h8, 32'h5555AAAA, 4'hF, 1'b1);
        do_read(4'h8, "bhold_r2");
        for (int i = 0; i < 5; i++) begin
            check("bhold_bvalid",  {31'b0, S_AXI_BVALID},  32'd1);
            check("bhold_awready", {31'b0, S_AXI_AWREADY}, 32'd0);
            check("bhold_wready",  {31'b0, S_AXI_WREADY},  32'd0);
            @(negedge tb_ACLK);
        end
        S_AXI_BREADY = 1'b1;
        @(negedge tb_ACLK);
        check("bhold_release", {31'b0, S_AXI_BVALID}, 32'd0);
        check("bhold_reg2_out", REG2_OUT, 32'h5555AAAA);

        // Read and write commit on the same edge to the same register
        @(negedge tb_ACLK);
        S_AXI_AWADDR  = 4'hC;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA   = 32'h0F0F0F0F;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_WVALID  = 1'b1;
        S_AXI_ARADDR  = 4'hC;
        S_AXI_ARVALID = 1'b1;
        S_AXI_RREADY  = 1'b1;
        S_AXI_BREADY  = 1'b1;
        check("coll_all_ready", {29'b0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'd7);
        rd_q.push_back(model[3]);
        b_q.push_back(2'b00);
        model[3] = 32'h0F0F0F0F;
        @(negedge tb_ACLK);
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_ARVALID = 1'b0;
        check("coll_rvalid", {31'b0, S_AXI_RVALID}, 32'd1);
        exp_tmp = rd_q.pop_front();
        check("coll_rdata_old", S_AXI_RDATA, exp_tmp);
        check("coll_bvalid", {31'b0, S_AXI_BVALID}, 32'd1);
        exp_tmp = {30'b0, b_q.pop_front()};
        check("coll_bresp", {30'b0, S_AXI_BRESP}, exp_tmp);
        @(negedge tb_ACLK);
        do_read(4'hC, "coll_r3_new");

        // Reset while a read response is pending and a W beat is latched
        @(negedge tb_ACLK);
        S_AXI_RREADY  = 1'b0;
        S_AXI_ARADDR  = 4'h8;
        S_AXI_ARVALID = 1'b1;
        S_AXI_AWADDR  = 4'h4;
        S_AXI_WDATA   = 32'hCAFEBABE;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_WVALID  = 1'b1;
        @(negedge tb_ACLK);
        S_AXI_ARVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        check("rstmid_rvalid_pre", {31'b0, S_AXI_RVALID}, 32'd1);
        ARESETN = 1'b0;
        @(negedge tb_ACLK);
        check("rstmid_rvalid", {31'b0, S_AXI_RVALID}, 32'd0);
        check("rstmid_bvalid", {31'b0, S_AXI_BVALID}, 32'd0);
        check("rstmid_reg1",   REG1_OUT, 32'h0);
        // An AW offered during reset must not pair with the abandoned W beat
        S_AXI_AWVALID = 1'b1;
        @(negedge tb_ACLK);
        S_AXI_AWVALID = 1'b0;
        ARESETN = 1'b1;
        S_AXI_RREADY = 1'b1;
        for (int i = 0; i < 4; i++) model[i] = '0;
        @(negedge tb_ACLK);
        check("rstmid_bvalid_after", {31'b0, S_AXI_BVALID}, 32'd0);
        do_read(4'h0, "rstmid_r0");
        do_read(4'h4, "rstmid_r1");
        do_read(4'h8, "rstmid_r2");
        do_read(4'hC, "rstmid_r3");
        do_write(4'h4, 32'h11112222, 4'hF, 1'b0);
        do_read(4'h4, "post_rst_r1");

        check("sb_rd_empty", rd_q.size(), 32'd0);
        check("sb_b_empty",  b_q.size(),  32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
